// File: rtl/song_recorder.sv
// Score recorder: quantises detected notes to a beat grid and writes one note per
// beat into a score RAM, closing the song with an end-of-song marker.
module song_recorder #(
  parameter int ADDR_W = 7,
  parameter int NOTE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [25:0]       tempo,
  input  logic [NOTE_W-1:0] detected_note,
  input  logic              note_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [NOTE_W-1:0] wr_data,
  output logic              recording,
  output logic              done,
  output logic [ADDR_W:0]   notes_written
);
  typedef enum logic [1:0] {IDLE, RECORD, TERMINATE, DONE} state_t;

  localparam logic [NOTE_W-1:0] END_MARK = '1;
  localparam logic [ADDR_W:0]   FULL     = {1'b0, {ADDR_W{1'b1}}};

  state_t            state, state_nx;
  logic [25:0]       tempo_q, beat_cnt;
  logic [NOTE_W-1:0] held, note_in, captured, wr_data_nx;
  logic [ADDR_W-1:0] addr, wr_addr_nx;
  logic              term_pend, beat, last_wr, wr_en_nx, arm;

  assign arm      = ((state == IDLE) || (state == DONE)) && start;
  assign beat     = (state == RECORD) && (beat_cnt == tempo_q - 26'd1);
  assign note_in  = (detected_note == END_MARK) ? '0 : detected_note;
  assign captured = note_valid ? note_in : held;
  // The beat write that must be followed by the end marker: stop hit a beat, or RAM is full.
  assign last_wr  = wr_en && (term_pend || (notes_written == FULL));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      recording <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      recording <= (state_nx == RECORD);
      done      <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = RECORD;
      RECORD:     if (last_wr || (stop && !beat)) state_nx = TERMINATE;
      TERMINATE:  state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;
    if (state_nx == TERMINATE) begin
      wr_en_nx   = 1'b1;
      wr_addr_nx = addr;
      wr_data_nx = END_MARK;
    end else if (beat) begin
      wr_en_nx   = 1'b1;
      wr_addr_nx = addr;
      wr_data_nx = captured;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tempo_q       <= 26'd2;
      beat_cnt      <= '0;
      held          <= '0;
      addr          <= '0;
      notes_written <= '0;
      term_pend     <= 1'b0;
    end else if (arm) begin
      tempo_q       <= (tempo < 26'd2) ? 26'd2 : tempo;
      beat_cnt      <= '0;
      held          <= '0;
      addr          <= '0;
      notes_written <= '0;
      term_pend     <= 1'b0;
    end else if (state == RECORD) begin
      if (beat) begin
        beat_cnt      <= '0;
        held          <= '0;
        addr          <= addr + ADDR_W'(1);
        notes_written <= notes_written + (ADDR_W+1)'(1);
        term_pend     <= stop;
      end else begin
        beat_cnt <= beat_cnt + 26'd1;
        if (note_valid) held <= note_in;
      end
    end
  end
endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder: a beat-grid model checked every cycle plus
// literal expectations on the captured write log for each scenario.
module tb_song_recorder;
  logic        clk = 1'b0;
  logic        reset, start, stop, note_valid;
  logic [25:0] tempo;
  logic [3:0]  detected_note;
  logic        wr_en, recording, done;
  logic [6:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [7:0]  notes_written;

  always #5 clk = ~clk;

  song_recorder #(.ADDR_W(7), .NOTE_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .tempo(tempo),
    .detected_note(detected_note), .note_valid(note_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .recording(recording), .done(done), .notes_written(notes_written)
  );

  int checks = 0, passed = 0, cyc_cnt = 0;
  int log_a[$], log_d[$], log_t[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    log_a.delete(); log_d.delete(); log_t.delete();
  endtask

  // Model: mode 0 idle, 1 recording, 2 terminating, 3 done. A beat lands every T
  // recording cycles; the address written is simply the number of notes so far.
  int m_mode = 0, m_T = 2, m_k = 0, m_held = 0, m_n = 0;
  bit m_fin = 0, e_wr = 0;
  int e_addr = 0, e_data = 0;

  always @(posedge clk) begin
    int nv;
    cyc_cnt++;
    e_wr = 0;
    if (reset) begin
      m_mode = 0; m_n = 0; m_held = 0;
    end else begin
      case (m_mode)
        0, 3: if (start) begin
          m_mode = 1; m_T = (tempo < 2) ? 2 : int'(tempo);
          m_k = 0; m_held = 0; m_n = 0; m_fin = 0;
        end
        1: begin
          m_k++;
          nv = note_valid ? ((detected_note == 4'hF) ? 0 : int'(detected_note)) : -1;
          if (m_k % m_T == 0) begin
            e_wr = 1; e_addr = m_n; e_data = (nv >= 0) ? nv : m_held;
            m_n++; m_held = 0;
            m_fin = stop || (m_n == 127);
          end else if (m_fin || stop) begin
            e_wr = 1; e_addr = m_n; e_data = 15; m_mode = 2;
          end else if (nv >= 0) m_held = nv;
        end
        2: m_mode = 3;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cyc_cnt > 0) begin
      check("wr_en", wr_en, e_wr);
      if (e_wr) begin
        check("wr_addr", wr_addr, e_addr);
        check("wr_data", wr_data, e_data);
      end
      check("recording", recording, m_mode == 1);
      check("done", done, m_mode == 3);
      check("notes_written", notes_written, m_n);
      if (wr_en === 1'b1) begin
        log_a.push_back(wr_addr); log_d.push_back(wr_data); log_t.push_back(cyc_cnt);
      end
    end
  end

  initial begin
    reset = 1; start = 0; stop = 0; note_valid = 0; tempo = 0; detected_note = 0;
    cyc(3); #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_recording", recording, 0);
    check("rst_done", done, 0);
    check("rst_notes_written", notes_written, 0);
    reset = 0;
    cyc(2);

    // tempo 10, note 3 for 25 cycles, stop at cycle 35
    clear_log();
    tempo = 10; detected_note = 3; note_valid = 1;
    cyc(4);
    start = 1; cyc(1); start = 0;
    cyc(20); note_valid = 0;
    cyc(14); stop = 1; cyc(1); stop = 0;
    cyc(3); #1;
    check("s1_count", log_a.size(), 4);
    if (log_a.size() == 4) begin
      check("s1_a0", log_a[0], 0); check("s1_d0", log_d[0], 3);
      check("s1_a1", log_a[1], 1); check("s1_d1", log_d[1], 3);
      check("s1_a2", log_a[2], 2); check("s1_d2", log_d[2], 0);
      check("s1_a3", log_a[3], 3); check("s1_d3", log_d[3], 15);
      check("s1_gap01", log_t[1] - log_t[0], 10);
      check("s1_gap12", log_t[2] - log_t[1], 10);
    end
    check("s1_done", done, 1);
    check("s1_nw", notes_written, 3);

    // tempo 4, end-marker code detected every cycle must be written as rest
    clear_log();
    tempo = 4; detected_note = 4'hF; note_valid = 1;
    start = 1; cyc(1); start = 0;
    cyc(18); stop = 1; cyc(1); stop = 0; note_valid = 0;
    cyc(3); #1;
    check("s2_count", log_a.size(), 5);
    if (log_a.size() == 5) begin
      for (int i = 0; i < 4; i++) check("s2_rest", log_d[i], 0);
      check("s2_mark_a", log_a[4], 4); check("s2_mark_d", log_d[4], 15);
    end

    // tempo 5, stop coinciding with the second beat
    clear_log();
    tempo = 5;
    start = 1; cyc(1); start = 0;
    cyc(2); note_valid = 1; detected_note = 7; cyc(1); note_valid = 0;
    cyc(6); stop = 1; cyc(1); stop = 0;
    cyc(3); #1;
    check("s3_count", log_a.size(), 3);
    if (log_a.size() == 3) begin
      check("s3_d0", log_d[0], 7);
      check("s3_a1", log_a[1], 1); check("s3_d1", log_d[1], 0);
      check("s3_a2", log_a[2], 2); check("s3_d2", log_d[2], 15);
      check("s3_back2back", log_t[2] - log_t[1], 1);
    end
    check("s3_nw", notes_written, 2);

    // tempo 0 clamps to 2; a start during recording is ignored
    clear_log();
    tempo = 0;
    start = 1; cyc(1); start = 0;
    cyc(2); start = 1; cyc(1); start = 0;
    note_valid = 1; detected_note = 5; cyc(1); note_valid = 0;
    cyc(4); stop = 1; cyc(1); stop = 0;
    cyc(3); #1;
    check("s4_count", log_a.size(), 5);
    if (log_a.size() == 5) begin
      check("s4_gap", log_t[1] - log_t[0], 2);
      check("s4_d1", log_d[1], 5);
      check("s4_a3", log_a[3], 3);
      check("s4_mark_a", log_a[4], 4);
      check("s4_mark_d", log_d[4], 15);
    end

    // reset (with a simultaneous start) after 5 writes aborts without a marker
    clear_log();
    tempo = 3;
    start = 1; cyc(1); start = 0;
    cyc(16);
    reset = 1; start = 1; cyc(1); #1;
    check("s5_wr_en", wr_en, 0);
    check("s5_wr_addr", wr_addr, 0);
    check("s5_wr_data", wr_data, 0);
    check("s5_recording", recording, 0);
    check("s5_done", done, 0);
    check("s5_nw", notes_written, 0);
    reset = 0; start = 0;
    cyc(3); #1;
    check("s5_count", log_a.size(), 5);
    check("s5_idle", recording, 0);
    if (log_a.size() == 5) check("s5_last_d", log_d[4], 0);

    // tempo 2 with no stop fills the RAM and self-terminates
    clear_log();
    tempo = 2;
    start = 1; cyc(1); start = 0;
    cyc(258);
    stop = 1; cyc(1); stop = 0;
    cyc(3); #1;
    check("s6_count", log_a.size(), 128);
    if (log_a.size() == 128) begin
      for (int i = 0; i < 128; i++) check("s6_addr", log_a[i], i);
      check("s6_d126", log_d[126], 0);
      check("s6_mark", log_d[127], 15);
    end
    check("s6_done", done, 1);
    check("s6_nw", notes_written, 127);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
